// File: rtl/tile_seq_pkg.sv
// Shared types for the tile clock/reset/isolation sequencer.
// Holds the per-domain state encoding, the registered-output bundle and the
// state-to-output lookup used by every domain FSM.
package tile_seq_pkg;

    localparam int unsigned MaxDomains = 8;

    typedef enum logic [2:0] {
        OFF        = 3'd0,
        PWR_UP     = 3'd1,
        RUN        = 3'd2,
        ISOLATE    = 3'd3,
        RST_ASSERT = 3'd4
    } dom_state_e;

    typedef struct packed {
        logic clk_en;
        logic rst_n;
        logic isolate;
        logic running;
        logic busy;
    } dom_outs_t;

    function automatic dom_outs_t dom_outs(input dom_state_e s);
        dom_outs_t o;
        o = '{clk_en: 1'b0, rst_n: 1'b0, isolate: 1'b1, running: 1'b0, busy: 1'b0};
        case (s)
            PWR_UP:     o = '{clk_en: 1'b1, rst_n: 1'b0, isolate: 1'b1, running: 1'b0, busy: 1'b1};
            RUN:        o = '{clk_en: 1'b1, rst_n: 1'b1, isolate: 1'b0, running: 1'b1, busy: 1'b0};
            ISOLATE:    o = '{clk_en: 1'b1, rst_n: 1'b1, isolate: 1'b1, running: 1'b0, busy: 1'b1};
            RST_ASSERT: o = '{clk_en: 1'b1, rst_n: 1'b0, isolate: 1'b1, running: 1'b0, busy: 1'b1};
            default:    o = '{clk_en: 1'b0, rst_n: 1'b0, isolate: 1'b1, running: 1'b0, busy: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tile_clk_rst_seq_if.sv
// Per-domain request/status bundle of the tile sequencer.
//   target_on_i   : level request per domain (1 = run)
//   isolate_ack_i : domain NoC port idle while isolated
//   clk_en_o      : clock-gate enable per domain
//   rst_no        : active-low domain reset
//   isolate_o     : block new handshakes at the domain boundary
//   running_o     : domain in RUN
//   busy_o        : domain in a transitional state
//   err_o         : sticky drain-timeout flag
// master = tile control side, slave = sequencer.
interface tile_clk_rst_seq_if #(
    parameter int unsigned NumDomains = 2
);
    logic [NumDomains-1:0] target_on_i;
    logic [NumDomains-1:0] isolate_ack_i;
    logic [NumDomains-1:0] clk_en_o;
    logic [NumDomains-1:0] rst_no;
    logic [NumDomains-1:0] isolate_o;
    logic [NumDomains-1:0] running_o;
    logic [NumDomains-1:0] busy_o;
    logic [NumDomains-1:0] err_o;

    modport master (
        output target_on_i, isolate_ack_i,
        input  clk_en_o, rst_no, isolate_o, running_o, busy_o, err_o
    );

    modport slave (
        input  target_on_i, isolate_ack_i,
        output clk_en_o, rst_no, isolate_o, running_o, busy_o, err_o
    );
endinterface

// File: rtl/tile_seq_dom_fsm.sv
// Single-domain power sequencer: OFF -> PWR_UP -> RUN -> ISOLATE -> RST_ASSERT -> OFF.
// Outputs are registered alongside the state transition.
//   clk_i, rst_ni   : always-on clock, async active-low reset
//   hold_i          : freeze state and counters (bypass)
//   target_on_i     : run request
//   isolate_ack_i   : domain drained while isolated
//   outs_o          : registered clk_en/rst_n/isolate/running/busy
//   err_o           : sticky drain-timeout flag
// Optional macro TILE_SEQ_DRAIN_TIMEOUT_EN adds the drain timeout counter;
// without it ISOLATE waits for the ack indefinitely and err_o is 0.
module tile_seq_dom_fsm
    import tile_seq_pkg::*;
#(
    parameter int unsigned RstHoldCycles = 4,
    parameter bit          ResetOn       = 1'b0,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      hold_i,
    input  logic      target_on_i,
    input  logic      isolate_ack_i,
    output dom_outs_t outs_o,
    output logic      err_o
);

    localparam int unsigned CntW     = $clog2(RstHoldCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(RstHoldCycles - 1);
    localparam dom_state_e  RstState = ResetOn ? PWR_UP : OFF;

`ifdef TILE_SEQ_DRAIN_TIMEOUT_EN
    localparam int unsigned TCntW    = $clog2(TimeoutCycles + 1);
    localparam logic [TCntW-1:0] TCntLast = TCntW'(TimeoutCycles - 1);
    logic [TCntW-1:0] tcnt;
    logic             err_q;
`endif

    dom_state_e      state;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= RstState;
            cnt    <= '0;
            outs_o <= dom_outs(RstState);
`ifdef TILE_SEQ_DRAIN_TIMEOUT_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else if (!hold_i) begin
            case (state)
                OFF: begin
                    if (target_on_i) begin
                        state  <= PWR_UP;
                        cnt    <= '0;
                        outs_o <= dom_outs(PWR_UP);
`ifdef TILE_SEQ_DRAIN_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                PWR_UP: begin
                    // Power-up completes regardless of target.
                    if (cnt == CntLast) begin
                        state  <= RUN;
                        cnt    <= '0;
                        outs_o <= dom_outs(RUN);
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                RUN: begin
                    if (!target_on_i) begin
                        state  <= ISOLATE;
                        cnt    <= '0;
                        outs_o <= dom_outs(ISOLATE);
`ifdef TILE_SEQ_DRAIN_TIMEOUT_EN
                        tcnt   <= '0;
`endif
                    end
                end
                ISOLATE: begin
                    // A returning request wins over a same-cycle ack: no reset is applied.
                    if (target_on_i) begin
                        state  <= RUN;
                        cnt    <= '0;
                        outs_o <= dom_outs(RUN);
                    end else if (isolate_ack_i) begin
                        state  <= RST_ASSERT;
                        cnt    <= '0;
                        outs_o <= dom_outs(RST_ASSERT);
`ifdef TILE_SEQ_DRAIN_TIMEOUT_EN
                    end else if (tcnt == TCntLast) begin
                        state  <= RST_ASSERT;
                        cnt    <= '0;
                        outs_o <= dom_outs(RST_ASSERT);
                        err_q  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCntW'(1);
`endif
                    end
                end
                RST_ASSERT: begin
                    if (cnt == CntLast) begin
                        state  <= OFF;
                        cnt    <= '0;
                        outs_o <= dom_outs(OFF);
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state  <= OFF;
                    cnt    <= '0;
                    outs_o <= dom_outs(OFF);
                end
            endcase
        end
    end

`ifdef TILE_SEQ_DRAIN_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/tile_clk_rst_seq.sv
// Tile clock/reset/isolation sequencer for NumDomains gated domains.
// One tile_seq_dom_fsm per domain; this level adds the bypass and DFT overrides.
//   clk_i            : always-on tile clock
//   rst_ni           : asynchronous active-low reset
//   test_enable_i    : forces all clock enables high
//   clk_rst_bypass_i : domains free-running and following rst_ni; FSMs frozen
//   dom (slave)      : target_on_i/isolate_ack_i in; clk_en_o, rst_no, isolate_o,
//                      running_o, busy_o, err_o out (NumDomains bits each)
// Optional macro TILE_SEQ_DRAIN_TIMEOUT_EN enables the ISOLATE drain timeout.
module tile_clk_rst_seq
    import tile_seq_pkg::*;
#(
    parameter int unsigned           NumDomains    = 2,
    parameter int unsigned           RstHoldCycles = 4,
    parameter logic [NumDomains-1:0] ResetOn       = '0,
    parameter int unsigned           TimeoutCycles = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               test_enable_i,
    input  logic               clk_rst_bypass_i,
    tile_clk_rst_seq_if.slave  dom
);

    if (NumDomains < 1 || NumDomains > MaxDomains || RstHoldCycles < 1 || TimeoutCycles < 1)
    begin : g_param_check
        $error("tile_clk_rst_seq: parameter out of range");
    end

    dom_outs_t             outs [NumDomains];
    logic [NumDomains-1:0] fsm_clk_en;
    logic [NumDomains-1:0] fsm_rst_n;
    logic [NumDomains-1:0] fsm_iso;
    logic [NumDomains-1:0] fsm_run;
    logic [NumDomains-1:0] fsm_busy;
    logic [NumDomains-1:0] fsm_err;

    for (genvar g = 0; g < NumDomains; g++) begin : g_dom
        tile_seq_dom_fsm #(
            .RstHoldCycles (RstHoldCycles),
            .ResetOn       (ResetOn[g]),
            .TimeoutCycles (TimeoutCycles)
        ) u_fsm (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .hold_i        (clk_rst_bypass_i),
            .target_on_i   (dom.target_on_i[g]),
            .isolate_ack_i (dom.isolate_ack_i[g]),
            .outs_o        (outs[g]),
            .err_o         (fsm_err[g])
        );
    end

    always_comb begin
        fsm_clk_en = '0;
        fsm_rst_n  = '0;
        fsm_iso    = '0;
        fsm_run    = '0;
        fsm_busy   = '0;
        for (int unsigned i = 0; i < NumDomains; i++) begin
            fsm_clk_en[i] = outs[i].clk_en;
            fsm_rst_n[i]  = outs[i].rst_n;
            fsm_iso[i]    = outs[i].isolate;
            fsm_run[i]    = outs[i].running;
            fsm_busy[i]   = outs[i].busy;
        end
    end

    assign dom.clk_en_o  = (clk_rst_bypass_i || test_enable_i) ? '1 : fsm_clk_en;
    assign dom.rst_no    = clk_rst_bypass_i ? {NumDomains{rst_ni}} : fsm_rst_n;
    assign dom.isolate_o = clk_rst_bypass_i ? '0 : fsm_iso;
    assign dom.running_o = fsm_run;
    assign dom.busy_o    = fsm_busy;
    assign dom.err_o     = fsm_err;

endmodule
